// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 8-digit 7-segment display
// scheduler.
//   disp_own_t   : display ownership state (idle, or owned by requester 0 or 1).
//   NDIG, NIB_W  : digit count and nibble width per digit.
//   IDX_W        : width of the digit scan index.
//   DATA_W       : width of one requester's packed display value.
//   digit_sel_n(): active-low one-hot digit select for a scan index.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } disp_own_t;

  localparam int NDIG   = 8;
  localparam int NIB_W  = 4;
  localparam int IDX_W  = $clog2(NDIG);
  localparam int DATA_W = NDIG * NIB_W;

  // Bit k low selects digit k; all other digits stay dark.
  function automatic logic [NDIG-1:0] digit_sel_n(input logic [IDX_W-1:0] idx);
    return ~(NDIG'(1) << idx);
  endfunction

endpackage

// File: rtl/disp_scan_timer.sv
// Digit scan timing for the multiplexed display.
// A prescaler counts CLK_DIV clocks per digit slot; the digit index advances
// once per slot and wraps after the last digit.
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous, active-high
//   idx_o         out  current digit index (0..NDIG-1)
//   tick_o        out  last clock of the current slot
//   bnd_o         out  last clock of the frame (tick in the last slot)
//   blank_o       out  current clock lies in the slot's blanking window
//   frame_start_o out  registered pulse in the first clock of slot 0
module disp_scan_timer
  import disp_pkg::*;
#(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 8
) (
  input  logic             clock,
  input  logic             reset,
  output logic [IDX_W-1:0] idx_o,
  output logic             tick_o,
  output logic             bnd_o,
  output logic             blank_o,
  output logic             frame_start_o
);

  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("disp_scan_timer: CLK_DIV must be >= 2");
    end
    if (BLANK_CYC >= CLK_DIV) begin : g_bad_blank
      $error("disp_scan_timer: BLANK_CYC must be < CLK_DIV");
    end
  endgenerate

  localparam int                 PRE_W     = $clog2(CLK_DIV);
  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0]   BLANK_END = PRE_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NDIG - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             frame_start_q;
  logic             tick;
  logic             bnd;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    bnd   = tick && (idx_q == IDX_LAST);
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
    idx_d = tick ? idx_q + IDX_W'(1) : idx_q;
  end

  // frame_start is registered from bnd so it rises exactly in the first
  // clock of slot 0, and stays low in the first clock after reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q         <= '0;
      idx_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      frame_start_q <= bnd;
    end
  end

  assign idx_o         = idx_q;
  assign tick_o        = tick;
  assign bnd_o         = bnd;
  assign blank_o       = (pre_q < BLANK_END);
  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/disp_scan_scheduler.sv
// Shares one 8-digit multiplexed 7-segment display between two requesters.
// Ownership is arbitrated round-robin only at frame boundaries, with a
// minimum hold of HOLD_FRAMES frames; the owner's value is snapshotted once
// per frame so a frame never mixes two values.
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   req[1:0]     in   level request per requester
//   data0/data1  in   packed 8-nibble values, nibble k shown on digit k
//   gnt[1:0]     out  one-hot owner, 0 when idle (registered)
//   digit[3:0]   out  nibble of the digit being scanned (registered)
//   seg_en       out  segment decoder enable (registered)
//   control[7:0] out  active-low digit enables (registered)
//   frame_start  out  one-clock pulse in the first clock of slot 0
module disp_scan_scheduler
  import disp_pkg::*;
#(
  parameter int CLK_DIV     = 1000,
  parameter int BLANK_CYC   = 8,
  parameter int HOLD_FRAMES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic [1:0]        gnt,
  output logic [NIB_W-1:0]  digit,
  output logic              seg_en,
  output logic [NDIG-1:0]   control,
  output logic              frame_start
);

  generate
    if (HOLD_FRAMES < 1) begin : g_bad_hold
      $error("disp_scan_scheduler: HOLD_FRAMES must be >= 1");
    end
  endgenerate

  localparam int                HOLD_W   = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_SW  = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(HOLD_FRAMES);

  logic [IDX_W-1:0] idx_w;
  logic             tick_w;
  logic             bnd_w;
  logic             blank_w;
  logic             frame_start_w;

  disp_scan_timer #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clock         (clock),
    .reset         (reset),
    .idx_o         (idx_w),
    .tick_o        (tick_w),
    .bnd_o         (bnd_w),
    .blank_o       (blank_w),
    .frame_start_o (frame_start_w)
  );

  disp_own_t         state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic              last_q, last_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [NIB_W-1:0]  digit_q, digit_d;
  logic              seg_en_q, seg_en_d;
  logic [NDIG-1:0]   control_q, control_d;
  logic              arb_en;
  logic              dark;

  // Arbitration happens on the last clock of the last slot only, so every
  // frame is displayed under one owner with one snapshot.
  assign arb_en   = tick_w && bnd_w;
  assign hold_inc = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    last_d   = last_q;
    shadow_d = shadow_q;
    gnt_d    = gnt_q;
    if (arb_en) begin
      unique case (state_q)
        IDLE: begin
          // Both asking: the one that did not own the display last wins.
          if (req[0] && req[1]) state_d = last_q ? OWN0 : OWN1;
          else if (req[0])      state_d = OWN0;
          else if (req[1])      state_d = OWN1;
          else                  state_d = IDLE;
        end
        OWN0: begin
          if (!req[0])                        state_d = req[1] ? OWN1 : IDLE;
          else if (req[1] && hold_q >= HOLD_SW) state_d = OWN1;
          else                                state_d = OWN0;
        end
        OWN1: begin
          if (!req[1])                        state_d = req[0] ? OWN0 : IDLE;
          else if (req[0] && hold_q >= HOLD_SW) state_d = OWN0;
          else                                state_d = OWN1;
        end
        default: state_d = IDLE;
      endcase

      unique case (state_d)
        OWN0: begin
          gnt_d    = 2'b01;
          shadow_d = data0;
          last_d   = 1'b0;
          hold_d   = (state_q == OWN0) ? hold_inc : '0;
        end
        OWN1: begin
          gnt_d    = 2'b10;
          shadow_d = data1;
          last_d   = 1'b1;
          hold_d   = (state_q == OWN1) ? hold_inc : '0;
        end
        default: begin
          gnt_d  = 2'b00;
          hold_d = '0;
        end
      endcase
    end
  end

  // Display outputs are registered from the current scan position, so they
  // trail the timer by one clock. The nibble tracks the scan even when dark.
  always_comb begin
    dark      = blank_w || (state_q == IDLE);
    control_d = dark ? {NDIG{1'b1}} : digit_sel_n(idx_w);
    seg_en_d  = !dark;
    digit_d   = shadow_q[NIB_W*idx_w +: NIB_W];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      last_q    <= 1'b1;
      shadow_q  <= '0;
      gnt_q     <= 2'b00;
      digit_q   <= '0;
      seg_en_q  <= 1'b0;
      control_q <= {NDIG{1'b1}};
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      shadow_q  <= shadow_d;
      gnt_q     <= gnt_d;
      digit_q   <= digit_d;
      seg_en_q  <= seg_en_d;
      control_q <= control_d;
    end
  end

  assign gnt         = gnt_q;
  assign digit       = digit_q;
  assign seg_en      = seg_en_q;
  assign control     = control_q;
  assign frame_start = frame_start_w;

endmodule

// File: tb/tb_disp_scan_scheduler.sv
// Self-checking bench for disp_scan_scheduler (CLK_DIV=4, BLANK_CYC=1,
// HOLD_FRAMES=2, so one frame is 32 clocks). A cycle model predicts the
// outputs of the next clock whenever inputs are applied; the prediction is
// queued and compared at the following falling edge.
module tb_disp_scan_scheduler;

  localparam int CLK_DIV     = 4;
  localparam int BLANK_CYC   = 1;
  localparam int HOLD_FRAMES = 2;

  logic        clock;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [1:0]  gnt;
  logic [3:0]  digit;
  logic        seg_en;
  logic [7:0]  control;
  logic        frame_start;

  disp_scan_scheduler #(
    .CLK_DIV     (CLK_DIV),
    .BLANK_CYC   (BLANK_CYC),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .data0       (data0),
    .data1       (data1),
    .gnt         (gnt),
    .digit       (digit),
    .seg_en      (seg_en),
    .control     (control),
    .frame_start (frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] gnt;
    logic [7:0] control;
    logic       seg_en;
    logic [3:0] digit;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;
  bit rand_d0  = 1'b0;

  // Model state for the clock the DUT is currently in.
  int          m_c;      // clocks since reset release
  int          m_owner;  // -1 idle, 0 or 1 owner
  int          m_hold;
  int          m_last;
  logic [31:0] m_shadow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_c      = 0;
    m_owner  = -1;
    m_hold   = 0;
    m_last   = 1;
    m_shadow = 32'h0;
    exp_q.delete();
  endtask

  // Predict the outputs the DUT shows in the clock after the next rising
  // edge, given the inputs currently applied.
  task automatic predict();
    exp_t e;
    int   pre;
    int   idx;
    int   nxt;
    int   oth;
    bit   dark;
    bit   bnd;
    pre  = m_c % CLK_DIV;
    idx  = (m_c / CLK_DIV) % 8;
    dark = (pre < BLANK_CYC) || (m_owner < 0);
    e.control = dark ? 8'hFF : ~(8'h01 << idx);
    e.seg_en  = !dark;
    e.digit   = 4'(m_shadow >> (4 * idx));
    bnd       = (pre == CLK_DIV - 1) && (idx == 7);
    e.fs      = bnd;
    if (bnd) begin
      if (m_owner < 0) begin
        if (req == 2'b11)      nxt = 1 - m_last;
        else if (req == 2'b01) nxt = 0;
        else if (req == 2'b10) nxt = 1;
        else                   nxt = -1;
      end else begin
        oth = 1 - m_owner;
        if (!req[m_owner])                              nxt = req[oth] ? oth : -1;
        else if (req[oth] && m_hold >= HOLD_FRAMES - 1) nxt = oth;
        else                                            nxt = m_owner;
      end
      if (nxt >= 0) begin
        if (nxt == m_owner) m_hold = (m_hold < HOLD_FRAMES) ? m_hold + 1 : m_hold;
        else                m_hold = 0;
        m_shadow = (nxt == 1) ? data1 : data0;
        m_last   = nxt;
      end else begin
        m_hold = 0;
      end
      m_owner = nxt;
    end
    e.gnt = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    m_c++;
    exp_q.push_back(e);
  endtask

  // Advance n clocks: predict from the applied inputs, then compare the DUT
  // against the popped prediction at the next falling edge.
  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (rand_d0) data0 = $urandom();
      predict();
      @(negedge clock);
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("gnt",         32'(gnt),         32'(e.gnt));
        chk("control",     32'(control),     32'(e.control));
        chk("seg_en",      32'(seg_en),      32'(e.seg_en));
        chk("digit",       32'(digit),       32'(e.digit));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        if (e.fs) begin
          n_frames++;
          $display("frame %0d: req=%b gnt=%b control=%h seg_en=%b digit=%h", n_frames, req, gnt,
                   control, seg_en, digit);
        end
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_control"},     32'(control),     32'hFF);
    chk({tag, "_seg_en"},      32'(seg_en),      32'd0);
    chk({tag, "_gnt"},         32'(gnt),         32'd0);
    chk({tag, "_digit"},       32'(digit),       32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset = 1'b0;
    req   = 2'b00;
    data0 = 32'h0;
    data1 = 32'h0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clock);
    chk_reset_outputs("reset");
    reset = 1'b0;
    model_reset();

    // Idle: display dark, frame_start every 32 clocks.
    run(96);

    // Requester 0 alone: granted at the next boundary, digits 0..7 scanned.
    req   = 2'b01;
    data0 = 32'h76543210;
    run(96);

    // Owner drops its request mid-frame: held until the boundary, then idle.
    run(13);
    req = 2'b00;
    run(70);

    // Reacquire, then assert reset in the middle of slot 5.
    req   = 2'b01;
    data0 = 32'hFEDCBA98;
    run(64);
    guard = 0;
    while (!(((m_c / CLK_DIV) % 8 == 5) && (m_c % CLK_DIV == 2)) && guard < 64) begin
      run(1);
      guard++;
    end
    chk("pre_reset_gnt", 32'(gnt), 32'h1);
    chk("pre_reset_control", 32'(control), 32'hDF);
    #1 reset = 1'b1;
    #1 chk_reset_outputs("async_reset");
    @(negedge clock);
    chk_reset_outputs("reset_held");

    // Both requesting from reset (last=1): requester 0 first, then 1 after
    // the hold time; mid-frame data changes must not appear.
    req   = 2'b11;
    data0 = 32'h89ABCDEF;
    data1 = 32'h13579BDF;
    reset = 1'b0;
    model_reset();
    run(40);
    data1 = 32'h2468ACE0;
    run(60);
    data1 = 32'h0F1E2D3C;
    run(60);

    // Requester 0 only, its value changing every clock: each frame shows the
    // value sampled at the preceding boundary.
    req     = 2'b01;
    rand_d0 = 1'b1;
    run(160);
    rand_d0 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
